mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit block data memory between the instruction-cache miss port (read-only) and the data-cache miss/write-back port (read/write).
- Sits between both cache controllers and the memory model.
- Presents each cache with a dedicated memory-style port using the same READ/WRITE/BUSYWAIT block handshake, so neither cache needs to know about the other.
- Serialises transactions: one owner at a time, each held until the memory completes.

Parameters:
ADDR_W, 28, block address width (byte address minus 4 offset bits)
BLOCK_W, 128, block data width

Ports:
CLK  in  1  clock, all state on rising edge
RESET_N  in  1  reset, asynchronous, active-low
I_READ  in  1  I-cache block read request
I_BLOCK_ADDR  in  ADDR_W  I-cache block address
I_BUSYWAIT  out  1  stall to I-cache
I_READDATA  out  BLOCK_W  block returned to I-cache
D_READ  in  1  D-cache block read request
D_WRITE  in  1  D-cache block write-back request
D_BLOCK_ADDR  in  ADDR_W  D-cache block address
D_WRITEDATA  in  BLOCK_W  D-cache write-back block
D_BUSYWAIT  out  1  stall to D-cache
D_READDATA  out  BLOCK_W  block returned to D-cache
MEM_READ  out  1  read strobe to memory
MEM_WRITE  out  1  write strobe to memory
MEM_BLOCK_ADDR  out  ADDR_W  address to memory
MEM_WRITEDATA  out  BLOCK_W  write block to memory
MEM_BUSYWAIT  in  1  memory busy
MEM_READDATA  in  BLOCK_W  memory read block

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE, owner NONE, seen_busy 0, read buffer 0, RR pointer = D.
  - All outputs 0, including both BUSYWAITs (gated by RESET_N).
  - Memory strobes drop immediately on reset mid-transaction; the aborted transaction is not replayed.
- States:
  - IDLE: no memory strobes. Arbitrate on each edge.
    - D wins if only D requests (D_READ|D_WRITE).
    - I wins if only I requests.
    - Both requesting: D wins (fixed priority; see Optional Feature).
    - Winner latched into owner; next state SERVE. Address and write data are registered at grant.
  - SERVE: drive MEM_READ/MEM_WRITE, MEM_BLOCK_ADDR and MEM_WRITEDATA from the grant registers.
    - D_READ and D_WRITE both high is illegal; it is treated as a write.
    - seen_busy sets on any edge with MEM_BUSYWAIT=1.
    - Completion: edge with MEM_BUSYWAIT=0 and seen_busy=1.
    - On completion, capture MEM_READDATA into the read buffer (reads only), clear seen_busy, and go to DONE.
  - DONE (exactly 1 cycle): strobes 0; owner's BUSYWAIT=0. Next state IDLE.
    - Requests seen in DONE are not arbitrated; the owner must drop its request after seeing BUSYWAIT low.
- BUSYWAIT, combinational, per side: asserted = RESET_N & request & !(state==DONE & owner==side).
  - The losing requester stays stalled across the whole foreign transaction.
- Read data: the read buffer drives both I_READDATA and D_READDATA.
  - Only the owner's copy is meaningful in DONE.
  - The buffer holds its value until the next read completion.
  - Write-backs leave the buffer unchanged.
- Request withdrawn mid-SERVE: the transaction still completes at memory. The result is discarded and the FSM passes through DONE to IDLE.
- Latency, uncontended:
  - Request edge: grant.
  - Next cycle: strobe.
  - Memory N busy cycles.
  - Then DONE.
  - Total overhead is 2 cycles above the memory latency.
- MEM_BUSYWAIT stuck low in SERVE: no completion (seen_busy=0); strobes are held.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin tie-break.
  - On contention, the side not matching the RR pointer wins.
  - The RR pointer updates to the last granted side at every grant.
  - Guarantees neither cache waits more than one foreign transaction.
- Undefined: fixed priority, D over I. RR pointer logic is absent.

Decomposition:
- Package mem_arbiter_pkg: state encoding (IDLE, SERVE, DONE), owner encoding (NONE, I, D), ADDR_W/BLOCK_W defaults.
- One sub-module, mem_arbiter_pick: combinational winner select from the two request lines and the RR pointer; fixed priority when the macro is absent.
- FSM, grant registers and read buffer stay in mem_arbiter.

Test Plan:
- D_READ only, addr 0x0000010, memory busy 5 cycles, returns 0xAAAA…AA -> MEM_READ high 6 cycles; D_READDATA=0xAAAA…AA when D_BUSYWAIT falls; I_BUSYWAIT stays 0.
- I_READ and D_WRITE raised same edge (addr 0x20 / 0x30) -> D write-back served first (MEM_WRITE, addr 0x30); I_BUSYWAIT held 1 throughout; I read follows (addr 0x20).
- With MEM_ARBITER_RR_EN: three back-to-back contended rounds -> grants alternate D, I, D. Without the macro -> D, D, D while D keeps requesting.
- RESET_N pulled low during SERVE of a D write -> MEM_WRITE and D_BUSYWAIT drop the same cycle; after release, state IDLE and read buffer 0.
- I_READ dropped midway through its own SERVE -> memory transaction completes; one DONE cycle; IDLE; subsequent D_READ granted normally.
- Memory never raises MEM_BUSYWAIT -> FSM remains in SERVE with strobe held; no spurious DONE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the block memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int BLOCK_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - winner select between I and D requests (MEM_ARBITER_RR_EN selects round-robin)
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
`ifdef MEM_ARBITER_RR_EN
    input  logic rr_last_d,
`endif
    output logic gnt_i,
    output logic gnt_d
);

    // On contention choose by tie-break rule, otherwise grant whoever asks
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
`ifdef MEM_ARBITER_RR_EN
            // The side that did not win last time goes first
            gnt_d = !rr_last_d;
            gnt_i = rr_last_d;
`else
            gnt_d = 1'b1;
`endif
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-cache and D-cache block traffic onto one memory port (MEM_ARBITER_RR_EN: round-robin tie-break)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_BLOCK_ADDR,
    output logic               I_BUSYWAIT,
    output logic [BLOCK_W-1:0] I_READDATA,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_BLOCK_ADDR,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic               D_BUSYWAIT,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_BLOCK_ADDR,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic               MEM_BUSYWAIT,
    input  logic [BLOCK_W-1:0] MEM_READDATA
);

    state_t               state;
    state_t               state_nxt;
    owner_t               owner;
    logic                 seen_busy;
    logic                 g_write;
    logic [ADDR_W-1:0]    g_addr;
    logic [BLOCK_W-1:0]   g_wdata;
    logic [BLOCK_W-1:0]   rbuf;
    logic                 req_i;
    logic                 req_d;
    logic                 gnt_i;
    logic                 gnt_d;
    logic                 complete;
`ifdef MEM_ARBITER_RR_EN
    logic                 rr_last_d;
`endif

    assign req_i    = I_READ;
    assign req_d    = D_READ | D_WRITE;
    assign complete = (state == ST_SERVE) && !MEM_BUSYWAIT && seen_busy;

    mem_arbiter_pick u_pick (
        .req_i     (req_i),
        .req_d     (req_d),
`ifdef MEM_ARBITER_RR_EN
        .rr_last_d (rr_last_d),
`endif
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    // Stall every requester except the owner during its single DONE cycle
    assign I_BUSYWAIT = RESET_N & req_i & !((state == ST_DONE) && (owner == OWN_I));
    assign D_BUSYWAIT = RESET_N & req_d & !((state == ST_DONE) && (owner == OWN_D));

    // One shared buffer feeds both caches; only the owner looks at it
    assign I_READDATA = rbuf;
    assign D_READDATA = rbuf;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory-side strobes
    always_comb begin
        state_nxt      = state;
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b0;
        MEM_BLOCK_ADDR = '0;
        MEM_WRITEDATA  = '0;
        case (state)
            ST_IDLE: begin
                if (gnt_i || gnt_d) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                MEM_READ       = !g_write;
                MEM_WRITE      = g_write;
                MEM_BLOCK_ADDR = g_addr;
                MEM_WRITEDATA  = g_wdata;
                if (complete) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant registers, busy tracking and read buffer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner     <= OWN_NONE;
            seen_busy <= 1'b0;
            g_write   <= 1'b0;
            g_addr    <= '0;
            g_wdata   <= '0;
            rbuf      <= '0;
`ifdef MEM_ARBITER_RR_EN
            rr_last_d <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_d) begin
                        owner   <= OWN_D;
                        g_addr  <= D_BLOCK_ADDR;
                        g_wdata <= D_WRITEDATA;
                        // Read and write together is treated as a write-back
                        g_write <= D_WRITE;
                    end else if (gnt_i) begin
                        owner   <= OWN_I;
                        g_addr  <= I_BLOCK_ADDR;
                        g_wdata <= '0;
                        g_write <= 1'b0;
                    end
`ifdef MEM_ARBITER_RR_EN
                    if (gnt_i || gnt_d) begin
                        rr_last_d <= gnt_d;
                    end
`endif
                end
                ST_SERVE: begin
                    if (MEM_BUSYWAIT) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        seen_busy <= 1'b0;
                        if (!g_write) begin
                            rbuf <= MEM_READDATA;
                        end
                    end
                end
                ST_DONE: begin
                    owner <= OWN_NONE;
                end
                default: begin
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory and reference model
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic         CLK;
    logic         RESET_N;
    logic         I_READ;
    logic [27:0]  I_BLOCK_ADDR;
    logic         I_BUSYWAIT;
    logic [127:0] I_READDATA;
    logic         D_READ;
    logic         D_WRITE;
    logic [27:0]  D_BLOCK_ADDR;
    logic [127:0] D_WRITEDATA;
    logic         D_BUSYWAIT;
    logic [127:0] D_READDATA;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_BLOCK_ADDR;
    logic [127:0] MEM_WRITEDATA;
    logic         MEM_BUSYWAIT;
    logic [127:0] MEM_READDATA;

    mem_arbiter dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .I_READ         (I_READ),
        .I_BLOCK_ADDR   (I_BLOCK_ADDR),
        .I_BUSYWAIT     (I_BUSYWAIT),
        .I_READDATA     (I_READDATA),
        .D_READ         (D_READ),
        .D_WRITE        (D_WRITE),
        .D_BLOCK_ADDR   (D_BLOCK_ADDR),
        .D_WRITEDATA    (D_WRITEDATA),
        .D_BUSYWAIT     (D_BUSYWAIT),
        .D_READDATA     (D_READDATA),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_BLOCK_ADDR (MEM_BLOCK_ADDR),
        .MEM_WRITEDATA  (MEM_WRITEDATA),
        .MEM_BUSYWAIT   (MEM_BUSYWAIT),
        .MEM_READDATA   (MEM_READDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: busy for 'lat' strobe cycles, then completes; data stored at completion
    logic [127:0] mem_arr [256];
    logic [127:0] ref_arr [256];
    int  lat       = 2;
    int  fixed_lat = 2;
    bit  rand_lat  = 1'b0;
    int  cnt       = 0;
    wire strobe_w  = MEM_READ | MEM_WRITE;

    assign MEM_BUSYWAIT = strobe_w && (cnt < lat);
    assign MEM_READDATA = mem_arr[MEM_BLOCK_ADDR[7:0]];

    always @(posedge CLK) begin
        if (!strobe_w) begin
            cnt <= 0;
            lat <= rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
        end else if (MEM_BUSYWAIT) begin
            cnt <= cnt + 1;
        end else if (MEM_WRITE && lat > 0) begin
            mem_arr[MEM_BLOCK_ADDR[7:0]] <= MEM_WRITEDATA;
        end
    end

    // Expected read data per side, pushed at request issue
    logic [127:0] i_q [$];
    logic [127:0] d_q [$];

    always @(negedge CLK) begin
        if (RESET_N && I_READ && !I_BUSYWAIT) begin
            if (i_q.size() == 0) chk("i_unexpected_done", 1'b1, 1'b0);
            else chk("i_rdata", I_READDATA, i_q.pop_front());
        end
        if (RESET_N && D_READ && !D_WRITE && !D_BUSYWAIT) begin
            if (d_q.size() == 0) chk("d_unexpected_done", 1'b1, 1'b0);
            else chk("d_rdata", D_READDATA, d_q.pop_front());
        end
    end

    // Grant-order and strobe-length monitor for the random phase
    bit rand_phase  = 1'b0;
    bit prev_strobe = 1'b0;
    bit prev_ri     = 1'b0;
    bit prev_rd     = 1'b0;
    bit m_last_d    = 1'b1;
    int run_len     = 0;
    bit win_i;
    bit exp_i;

    always @(negedge CLK) begin
        if (rand_phase && strobe_w && !prev_strobe) begin
            win_i = MEM_BLOCK_ADDR[7];
            if (prev_ri && prev_rd) exp_i = RR_EN ? m_last_d : 1'b0;
            else exp_i = prev_ri;
            chk("grant_side", win_i, exp_i);
            m_last_d = !exp_i;
        end
        if (strobe_w) begin
            run_len++;
        end else if (run_len > 0) begin
            if (rand_phase) chk("strobe_len", run_len, lat + 1);
            run_len = 0;
        end
        prev_strobe = strobe_w;
        prev_ri     = I_READ;
        prev_rd     = D_READ | D_WRITE;
    end

    task automatic d_xfer(input bit wr, input logic [7:0] a, input logic [127:0] wd);
        int k;
        @(posedge CLK); #1;
        D_READ       = !wr;
        D_WRITE      = wr;
        D_BLOCK_ADDR = {20'd0, a};
        D_WRITEDATA  = wd;
        if (wr) ref_arr[a] = wd;
        else d_q.push_back(ref_arr[a]);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (D_BUSYWAIT && k < 300);
        chk("d_done", D_BUSYWAIT, 1'b0);
        @(posedge CLK); #1;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    task automatic i_xfer(input logic [7:0] a);
        int k;
        @(posedge CLK); #1;
        I_READ       = 1'b1;
        I_BLOCK_ADDR = {20'd0, a};
        i_q.push_back(ref_arr[a]);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (I_BUSYWAIT && k < 300);
        chk("i_done", I_BUSYWAIT, 1'b0);
        @(posedge CLK); #1;
        I_READ = 1'b0;
    endtask

    task automatic wait_strobe();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (MEM_READ | MEM_WRITE) begin
                ok = 1'b1;
                break;
            end
        end
        chk("strobe_seen", ok, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit flag;
        logic [127:0] wd;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = {4{32'hC0DE_0000 | i}};
            ref_arr[i] = {4{32'hC0DE_0000 | i}};
        end
        mem_arr[8'h10] = {16{8'hAA}};
        ref_arr[8'h10] = {16{8'hAA}};
        RESET_N = 1'b0;
        I_READ = 1'b1; I_BLOCK_ADDR = '0;
        D_READ = 1'b0; D_WRITE = 1'b0; D_BLOCK_ADDR = '0; D_WRITEDATA = '0;
        repeat (3) @(negedge CLK);
        chk("rst_i_bw", I_BUSYWAIT, 1'b0);
        chk("rst_d_bw", D_BUSYWAIT, 1'b0);
        chk("rst_mem_rd", MEM_READ, 1'b0);
        chk("rst_mem_wr", MEM_WRITE, 1'b0);
        chk("rst_mem_addr", MEM_BLOCK_ADDR, 0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 0);
        chk("rst_i_rdata", I_READDATA, 0);
        chk("rst_d_rdata", D_READDATA, 0);
        I_READ = 1'b0;
        @(posedge CLK); #1 RESET_N = 1'b1;

        // Random traffic: I reads 0x80-0xFF, D reads/writes 0x60-0x6F
        rand_phase = 1'b1;
        rand_lat   = 1'b1;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 3)) @(posedge CLK);
                    i_xfer(8'h80 | 8'($urandom_range(0, 127)));
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 3)) @(posedge CLK);
                    d_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(8'h60, 8'h6F)),
                           {$urandom, $urandom, $urandom, $urandom});
                end
            end
        join
        rand_phase = 1'b0;
        rand_lat   = 1'b0;
        repeat (3) @(posedge CLK);

        // Uncontended D read, 5 busy cycles
        fixed_lat = 5;
        repeat (2) @(posedge CLK);
        fork
            d_xfer(1'b0, 8'h10, '0);
            begin
                wait_strobe();
                n = 0; flag = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    if (!MEM_READ) break;
                    n++;
                    if (I_BUSYWAIT) flag = 1'b1;
                    @(negedge CLK);
                end
                chk("t1_read_len", n, 6);
                chk("t1_i_bw", flag, 1'b0);
            end
        join

        // Same-edge I read and D write-back
        fixed_lat = 3;
        repeat (2) @(posedge CLK);
        wd = {4{32'h1234_5678}};
        fork
            d_xfer(1'b1, 8'h30, wd);
            i_xfer(8'h20);
            begin
                wait_strobe();
                chk("t2_first_addr", MEM_BLOCK_ADDR, RR_EN ? 28'h20 : 28'h30);
                chk("t2_first_wr", MEM_WRITE, !RR_EN);
                flag = 1'b1;
                for (int k = 0; k < 100; k++) begin
                    if (!(MEM_READ | MEM_WRITE)) break;
                    if ((RR_EN ? D_BUSYWAIT : I_BUSYWAIT) !== 1'b1) flag = 1'b0;
                    @(negedge CLK);
                end
                chk("t2_loser_stalled", flag, 1'b1);
                wait_strobe();
                chk("t2_second_addr", MEM_BLOCK_ADDR, RR_EN ? 28'h30 : 28'h20);
            end
        join
        d_xfer(1'b0, 8'h30, '0);

        // I read withdrawn mid-transaction
        fixed_lat = 4;
        repeat (2) @(posedge CLK);
        @(posedge CLK); #1;
        I_READ = 1'b1; I_BLOCK_ADDR = 28'h90;
        wait_strobe();
        n = 1;
        @(posedge CLK); #1 I_READ = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (!(MEM_READ | MEM_WRITE)) break;
            n++;
        end
        chk("t5_len", n, 5);
        @(negedge CLK);
        chk("t5_idle_a", MEM_READ | MEM_WRITE, 1'b0);
        @(negedge CLK);
        chk("t5_idle_b", MEM_READ | MEM_WRITE, 1'b0);
        d_xfer(1'b0, 8'h11, '0);

        // Reset during a D write-back
        fixed_lat = 5;
        repeat (2) @(posedge CLK);
        @(posedge CLK); #1;
        D_WRITE = 1'b1; D_BLOCK_ADDR = 28'h40; D_WRITEDATA = {4{32'hDEAD_BEEF}};
        wait_strobe();
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1 RESET_N = 1'b0;
        #1;
        chk("t4_mem_wr_drop", MEM_WRITE, 1'b0);
        chk("t4_d_bw_drop", D_BUSYWAIT, 1'b0);
        D_WRITE = 1'b0;
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(negedge CLK);
        chk("t4_strobes_idle", MEM_READ | MEM_WRITE, 1'b0);
        chk("t4_rbuf_cleared", D_READDATA, 0);
        chk("t4_rbuf_cleared_i", I_READDATA, 0);
        d_xfer(1'b0, 8'h40, '0);

        // Memory never busy: strobe held, no completion
        fixed_lat = 0;
        repeat (2) @(posedge CLK);
        @(posedge CLK); #1;
        D_READ = 1'b1; D_BLOCK_ADDR = 28'h50;
        wait_strobe();
        flag = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (MEM_READ !== 1'b1 || D_BUSYWAIT !== 1'b1) flag = 1'b0;
        end
        chk("t6_stuck_serve", flag, 1'b1);
        @(posedge CLK); #1 RESET_N = 1'b0;
        D_READ = 1'b0;
        fixed_lat = 2;
        @(posedge CLK); #1 RESET_N = 1'b1;
        repeat (3) @(posedge CLK);

        chk("i_q_drained", i_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
